// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: ALU control codes
// (matching the control decoder) and the iteration FSM encoding.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CTL_W = 5;

    localparam logic [4:0] ALU_MUL    = 5'd2;
    localparam logic [4:0] ALU_MULH   = 5'd3;
    localparam logic [4:0] ALU_MULHSU = 5'd4;
    localparam logic [4:0] ALU_MULHU  = 5'd5;
    localparam logic [4:0] ALU_DIV    = 5'd6;
    localparam logic [4:0] ALU_DIVU   = 5'd7;
    localparam logic [4:0] ALU_REM    = 5'd8;
    localparam logic [4:0] ALU_REMU   = 5'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIN,
        ST_SPEC
    } state_e;

    function automatic logic is_md_op(input logic [4:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One step of the iterative datapath: shift-add multiply or restoring divide
// on a {acc, sreg} pair. Purely combinational.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] sreg_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] sreg_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rshift;
    logic            ge;
    logic [XLEN-1:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i} + (sreg_i[0] ? {1'b0, opnd_i} : '0);
        rshift = {acc_i, sreg_i[XLEN-1]};
        ge     = rshift >= {1'b0, opnd_i};
        // result of a successful subtract is below the divisor, so it fits XLEN bits
        diff   = rshift[XLEN-1:0] - opnd_i;
        if (is_div) begin
            acc_o  = ge ? diff : rshift[XLEN-1:0];
            sreg_o = {sreg_i[XLEN-2:0], ge};
        end else begin
            acc_o  = sum[XLEN:1];
            sreg_o = {sum[0], sreg_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Operands are reduced to magnitudes at accept; the sign is restored at FIN.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CTL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CTL_W-1:0] alu_ctl,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result
);
    import muldiv_pkg::*;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [CTL_W-1:0]  op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   sreg_q, sreg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              a_signed, b_signed, neg_a, neg_b, in_div, div_zero, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, iter_acc, iter_sreg, fin_res;
    logic [2*XLEN-1:0] prod;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div (op_q >= ALU_DIV),
        .acc_i  (acc_q),
        .sreg_i (sreg_q),
        .opnd_i (opnd_q),
        .acc_o  (iter_acc),
        .sreg_o (iter_sreg)
    );

    always_comb begin
        a_signed = (alu_ctl == ALU_MUL) || (alu_ctl == ALU_MULH) || (alu_ctl == ALU_MULHSU) ||
                   (alu_ctl == ALU_DIV) || (alu_ctl == ALU_REM);
        b_signed = (alu_ctl == ALU_MUL) || (alu_ctl == ALU_MULH) ||
                   (alu_ctl == ALU_DIV) || (alu_ctl == ALU_REM);
        neg_a    = a_signed && op_a[XLEN-1];
        neg_b    = b_signed && op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        in_div   = alu_ctl >= ALU_DIV;
        div_zero = op_b == '0;
        ovf      = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1) &&
                   ((alu_ctl == ALU_DIV) || (alu_ctl == ALU_REM));
    end

    // Final sign fix-up: quotient and product share neg_q; remainder follows the dividend.
    always_comb begin
        prod = {acc_q, sreg_q};
        if (neg_q) prod = -prod;
        case (op_q)
            ALU_MUL:             fin_res = prod[XLEN-1:0];
            ALU_DIV, ALU_DIVU:   fin_res = neg_q ? -sreg_q : sreg_q;
            ALU_REM, ALU_REMU:   fin_res = neg_q ? -acc_q : acc_q;
            default:             fin_res = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        sreg_d   = sreg_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && is_md_op(alu_ctl)) begin
                    op_d  = alu_ctl;
                    cnt_d = '0;
                    if (in_div && div_zero) begin
                        state_d = ST_SPEC;
                        acc_d   = ((alu_ctl == ALU_DIV) || (alu_ctl == ALU_DIVU)) ? '1 : op_a;
                    end else if (ovf) begin
                        state_d = ST_SPEC;
                        acc_d   = (alu_ctl == ALU_DIV) ? op_a : '0;
                    end else begin
                        state_d = ST_CALC;
                        acc_d   = '0;
                        sreg_d  = mag_a;
                        opnd_d  = mag_b;
                        neg_d   = (alu_ctl == ALU_REM) ? neg_a : (neg_a ^ neg_b);
                    end
                end
            end
            ST_CALC: begin
                acc_d  = iter_acc;
                sreg_d = iter_sreg;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_FIN;
            end
            ST_FIN: begin
                result_d = fin_res;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            sreg_q   <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            sreg_q   <= sreg_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = state_q != ST_IDLE;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, handshake and
// abort scenarios, and randomized operations against an arithmetic reference.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [4:0]  alu_ctl;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .CTL_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .alu_ctl (alu_ctl),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (c)
            5'd2: begin p = sa * sb; return p[31:0]; end
            5'd3: begin p = sa * sb; return p[63:32]; end
            5'd4: begin p = sa * ub; return p[63:32]; end
            5'd5: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'd6: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = $signed(a) / $signed(b);
                return q;
            end
            5'd7: return (b == 0) ? 32'hFFFFFFFF : a / b;
            5'd8: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_spec(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        return (c >= 5'd6 && b == 0) ||
               ((c == 5'd6 || c == 5'd8) && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    // Issue in the current cycle, then follow the op to its done pulse.
    task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hammer, input string tag);
        int n;
        bit seen;
        int lat;
        lat = is_spec(c, a, b) ? 1 : 33;
        start = 1'b1; alu_ctl = c; op_a = a; op_b = b;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL %s accept busy: got %b want 1", tag, busy);
        end
        start = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            op_a = $urandom; op_b = $urandom; alu_ctl = 5'($urandom_range(2, 9));
            start = (hammer && n < 20) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) seen = 1;
            else begin
                checks++;
                if (busy !== 1'b1) begin
                    fails++; $display("FAIL %s busy dropped at cycle %0d without done", tag, n);
                    n = 99;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (!seen || n != lat) begin
            fails++; $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, n, seen, lat);
        end
        checks++;
        if (result !== exp) begin
            fails++; $display("FAIL %s result: got %h want %h", tag, result, exp);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL %s busy after done: got %b want 0", tag, busy);
        end
        last_res = exp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_ctl = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            fails++; $display("FAIL reset: busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        end
        rst_n = 1'b1;
        last_res = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        run_op(5'd2, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul");
        run_op(5'd3, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh");
        run_op(5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu");
        run_op(5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu");
    endtask

    task automatic test_div();
        run_op(5'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, "div");
        run_op(5'd8, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, "rem");
        run_op(5'd7, 32'd100,      32'd7, 32'd14,       0, "divu");
        run_op(5'd9, 32'd100,      32'd7, 32'd2,        0, "remu");
    endtask

    task automatic test_special();
        run_op(5'd6, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "div0");
        run_op(5'd7, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "divu0");
        run_op(5'd8, 32'd5, 32'd0, 32'd5,        0, "rem0");
        run_op(5'd9, 32'd5, 32'd0, 32'd5,        0, "remu0");
        run_op(5'd6, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
        run_op(5'd8, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, "rem_ovf");
    endtask

    task automatic test_ignored();
        logic [4:0] bad [3] = '{5'd0, 5'd10, 5'd31};
        foreach (bad[i]) begin
            start = 1'b1; alu_ctl = bad[i]; op_a = 32'd9; op_b = 32'd3;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
                fails++; $display("FAIL ignored_code %0d: busy=%b done=%b result=%h want 0/0/%h",
                                  bad[i], busy, done, result, last_res);
            end
        end
        start = 1'b1; flush = 1'b1; alu_ctl = 5'd2; op_a = 32'd9; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL start_with_flush busy: got %b want 0", busy);
        end
        run_op(5'd2, 32'd5, 32'd6, 32'd30, 1, "start_while_busy");
        run_op(5'd7, 32'd1000, 32'd9, 32'd111, 1, "start_while_busy_div");
    endtask

    task automatic test_back_to_back();
        run_op(5'd2, 32'd3,  32'd3, 32'd9, 0, "b2b_1");
        run_op(5'd9, 32'd17, 32'd0, 32'd17, 0, "b2b_spec");
        run_op(5'd7, 32'd17, 32'd5, 32'd3, 0, "b2b_2");
    endtask

    // Flush arrives at edge E<k>; chain=1 issues MUL 3x4 in the very next cycle.
    task automatic test_flush_at(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input int k, input bit chain, input string tag);
        start = 1'b1; alu_ctl = c; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (k - 1) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
            fails++; $display("FAIL %s after flush: busy=%b done=%b result=%h want 0/0/%h",
                              tag, busy, done, result, last_res);
        end
        if (chain) run_op(5'd2, 32'd3, 32'd4, 32'd12, 0, {tag, "_mul"});
        else begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    fails++; $display("FAIL %s late done: done=%b busy=%b want 0/0", tag, done, busy);
                end
            end
        end
    endtask

    task automatic test_flush();
        test_flush_at(5'd6, 32'd1000, 32'd7, 10, 1, "flush_e10");
        test_flush_at(5'd3, 32'h12345678, 32'h9ABCDEF0, 33, 0, "flush_e33");
        test_flush_at(5'd6, 32'd44, 32'd0, 1, 0, "flush_spec_e1");
    endtask

    task automatic test_reset_mid();
        int ndone;
        run_op(5'd2, 32'd11, 32'd13, 32'd143, 0, "pre_reset");
        start = 1'b1; alu_ctl = 5'd6; op_a = 32'd999; op_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            fails++; $display("FAIL reset_mid: busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        end
        last_res = 32'd0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            fails++; $display("FAIL reset_mid stray done: got %0d pulses want 0", ndone);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [4:0]  c;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            c = 5'($urandom_range(2, 9));
            a = pick_operand();
            b = pick_operand();
            run_op(c, a, b, model(c, a, b), 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, c));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignored();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
